mainfsm_ws: RTL and testbench
=============================

# mainfsm_ws

Parametrised multicycle control FSM for the ARM multicycle datapath. It extends the FETCH/DECODE/EXECUTE control sequence with four additions:
- a memory request/ready handshake, so memory wait states are tolerated;
- a counted multi-cycle multiply state;
- a memory-timeout fault;
- an illegal-opcode flag.

It sits in the controller between the instruction decoder and the datapath. It drives the same control word as the single-latency FSM.

## Interface
Parameters:
- MUL_CYCLES, default 4: cycles spent in MULEX (minimum 1).
- TIMEOUT, default 255: maximum wait cycles in a memory state before FAULT; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20].
- MulOp  in  1  decoder flag: instruction is MUL (Op=00, Funct[5]=0, bits[7:4]=1001).
- MemReady  in  1  memory completes the current access this cycle.
- MemReq  out  1  memory access request.
- IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp  out  1 each  datapath controls.
- ALUSrcA, ALUSrcB, ResultSrc  out  2 each  datapath mux selects.
- MulStart  out  1  one-cycle pulse to the iterative multiplier.
- Illegal  out  1  one-cycle pulse when an undefined Op is decoded.
- Fault  out  1  sticky memory-timeout flag.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, MULEX, ALUWB, BRANCH, UNKNOWN, FAULT.
- FETCH:
  - Controls: MemReq=1, AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - IRWrite=NextPC=MemReady.
  - Stays in FETCH until MemReady=1, then goes to DECODE.
- DECODE:
  - Controls: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - Next state is selected in priority order:
    - Op=00 and MulOp=1 → MULEX.
    - Op=00 and Funct[5]=1 → EXECUTEI.
    - Op=00 otherwise → EXECUTER.
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=11 → UNKNOWN.
- EXECUTER: ALUOp=1, ALUSrcB=00 → ALUWB.
- EXECUTEI: ALUOp=1, ALUSrcB=01 → ALUWB.
- MULEX:
  - MulStart=1 on the first cycle only.
  - Stays for exactly MUL_CYCLES cycles, then → ALUWB.
  - ALUWB is unchanged; the multiplier result is muxed in the datapath.
- ALUWB: RegW=1, ResultSrc=00 → FETCH.
- MEMADR: ALUSrcB=01 → MEMRD if Funct[0]=1, else → MEMWR.
- MEMRD:
  - Controls: MemReq=1, AdrSrc=1.
  - Held until MemReady, then → MEMWB.
- MEMWR:
  - Controls: MemReq=1, AdrSrc=1, MemW=MemReady.
  - Held until MemReady, then → FETCH.
- MEMWB: RegW=1, ResultSrc=01 → FETCH.
- BRANCH: Branch=1, ALUSrcA=10, ALUSrcB=01, ResultSrc=10 → FETCH.
- UNKNOWN: all controls 0; Illegal=1 for one cycle → FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR.
  - Increments on each cycle in which MemReq=1 and MemReady=0.
  - When TIMEOUT≠0 and the counter reaches TIMEOUT while still waiting, the next state is FAULT.
- FAULT:
  - All controls 0, MemReq=0, Fault=1.
  - Terminal until reset.
- Any control not listed for a state is 0. Outputs are decoded combinationally from state (plus MemReady where noted); no output is X in any state.

## Timing
- Reset asserted (reset=0):
  - State goes to FETCH immediately (asynchronous); counters clear; Fault=0.
  - Outputs take FETCH values: MemReq=1, IRWrite=NextPC=0 unless MemReady=1.
- Reset mid-operation aborts any wait or multiply. MemW is already low in FETCH.
- Zero-wait memory: FETCH→DECODE takes 1 cycle.
- Per-instruction-class latency, with zero wait states:
  - Data-processing: 4 cycles.
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Branch: 3 cycles.
  - MUL: 3+MUL_CYCLES cycles.
- Each wait cycle adds 1 cycle.
- MemReady is sampled only in FETCH, MEMRD and MEMWR; it is ignored elsewhere.
- Timeout: with TIMEOUT=N, the FSM makes N waiting cycles. If MemReady=0 on the N-th, it enters FAULT on the next edge. MemReady=1 on that same cycle wins: normal transition.
- The wait counter saturates; it is never compared when TIMEOUT=0.

## Test plan
- ADD (Op=00, Funct=000000), MemReady=1 always → state sequence FETCH, DECODE, EXECUTER, ALUWB, FETCH; RegW=1 only in cycle 4.
- LDR (Op=01, Funct[0]=1) with MemReady low for 3 cycles in MEMRD → MEMRD held 4 cycles, AdrSrc=1 throughout, then MEMWB with RegW=1, ResultSrc=01.
- MUL (MulOp=1), MUL_CYCLES=4 → MulStart pulses once; MULEX lasts exactly 4 cycles, then ALUWB.
- TIMEOUT=8, MemReady=0 forever in FETCH → FAULT entered after 8 wait cycles; Fault=1 and MemReq=0 held; reset=0 returns to FETCH with Fault=0.
- Op=11 in DECODE → UNKNOWN for one cycle, Illegal=1 pulse, all controls 0, then FETCH.
- Reset asserted during MEMWR wait with MemReady=0 → state goes to FETCH without a clock edge; MemW never asserted.

Source files
------------

// File: rtl/mainfsm_ws.sv
`timescale 1ns/1ps
// Multicycle ARM control FSM with memory wait states, counted multiply, timeout fault and illegal-op flag.
// Outputs decode from state (plus MemReady in FETCH/MEMWR); memory states stall until MemReady or timeout.
module mainfsm_ws #(
    parameter int MUL_CYCLES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       MulOp,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       IRWrite,
    output logic       AdrSrc,
    output logic       NextPC,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       MulStart,
    output logic       Illegal,
    output logic       Fault
);

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam int MUL_W  = (MUL_CYCLES < 2) ? 1 : $clog2(MUL_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [MUL_W-1:0]  MUL_LAST  = MUL_W'((MUL_CYCLES < 1) ? 0 : MUL_CYCLES - 1);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER,
        EXECUTEI, MULEX, ALUWB, BRANCH, UNKNOWN, FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [MUL_W-1:0]    mul_cnt_q, mul_cnt_d;
    logic                timeout_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FETCH;
            wait_cnt_q <= '0;
            mul_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mul_cnt_q  <= mul_cnt_d;
        end
    end

    // Timeout fires on the TIMEOUT-th consecutive waiting cycle; a ready on that cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) && !MemReady && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        state_d   = state_q;
        MemReq    = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        MulStart  = 1'b0;
        Illegal   = 1'b0;
        Fault     = 1'b0;
        case (state_q)
            FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
                if (MemReady)         state_d = DECODE;
                else if (timeout_hit) state_d = FAULT;
            end
            DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b00: begin
                        if (MulOp)         state_d = MULEX;
                        else if (Funct[5]) state_d = EXECUTEI;
                        else               state_d = EXECUTER;
                    end
                    2'b01:   state_d = MEMADR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = UNKNOWN;
                endcase
            end
            EXECUTER: begin
                ALUOp   = 1'b1;
                state_d = ALUWB;
            end
            EXECUTEI: begin
                ALUOp   = 1'b1;
                ALUSrcB = 2'b01;
                state_d = ALUWB;
            end
            MULEX: begin
                MulStart = (mul_cnt_q == '0);
                if (mul_cnt_q == MUL_LAST) state_d = ALUWB;
            end
            ALUWB: begin
                RegW    = 1'b1;
                state_d = FETCH;
            end
            MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                if (MemReady)         state_d = MEMWB;
                else if (timeout_hit) state_d = FAULT;
            end
            MEMWR: begin
                MemReq = 1'b1;
                AdrSrc = 1'b1;
                MemW   = MemReady;
                if (MemReady)         state_d = FETCH;
                else if (timeout_hit) state_d = FAULT;
            end
            MEMWB: begin
                RegW      = 1'b1;
                ResultSrc = 2'b01;
                state_d   = FETCH;
            end
            BRANCH: begin
                Branch    = 1'b1;
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                state_d   = FETCH;
            end
            UNKNOWN: begin
                Illegal = 1'b1;
                state_d = FETCH;
            end
            FAULT: begin
                Fault = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Any state change restarts both counters, so each memory or multiply visit counts from zero.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        mul_cnt_d  = mul_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
            mul_cnt_d  = '0;
        end else begin
            if (MemReq && !MemReady && (wait_cnt_q != '1)) wait_cnt_d = wait_cnt_q + 1'b1;
            if (state_q == MULEX)                          mul_cnt_d  = mul_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_mainfsm_ws.sv
`timescale 1ns/1ps
// Instruction-level reference model feeding an expected-control-word queue; a negedge monitor pops and compares.
module tb_mainfsm_ws;

    localparam int MULC = 4;
    localparam int TO   = 8;

    localparam int P_FETCH = 0, P_DECODE = 1, P_EXR = 2, P_EXI = 3, P_MULF = 4, P_MUL = 5, P_AWB = 6,
                   P_MADR = 7, P_MRD = 8, P_MWR = 9, P_MWB = 10, P_BR = 11, P_UNK = 12, P_FAULT = 13;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic MulOp, MemReady;
    logic MemReq, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp, MulStart, Illegal, Fault;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [16:0] got;

    typedef struct {
        logic [16:0] w;
        string       tag;
    } exp_t;

    exp_t expq[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mainfsm_ws #(.MUL_CYCLES(MULC), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .MemReady(MemReady),
        .MemReq(MemReq), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .NextPC(NextPC), .RegW(RegW),
        .MemW(MemW), .Branch(Branch), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .MulStart(MulStart), .Illegal(Illegal), .Fault(Fault)
    );

    assign got = {MemReq, IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp,
                  ALUSrcA, ALUSrcB, ResultSrc, MulStart, Illegal, Fault};

    function automatic string pname(input int ph);
        case (ph)
            P_FETCH:  return "FETCH";
            P_DECODE: return "DECODE";
            P_EXR:    return "EXECUTER";
            P_EXI:    return "EXECUTEI";
            P_MULF:   return "MULEX_first";
            P_MUL:    return "MULEX";
            P_AWB:    return "ALUWB";
            P_MADR:   return "MEMADR";
            P_MRD:    return "MEMRD";
            P_MWR:    return "MEMWR";
            P_MWB:    return "MEMWB";
            P_BR:     return "BRANCH";
            P_UNK:    return "UNKNOWN";
            default:  return "FAULT";
        endcase
    endfunction

    // Control-word table written straight from the per-state control lists.
    function automatic logic [16:0] cw(input int ph, input bit r);
        logic mreq, irw, adr, npc, regw, memw, br, aop, mst, ill, flt;
        logic [1:0] a, b, res;
        {mreq, irw, adr, npc, regw, memw, br, aop, mst, ill, flt} = '0;
        a = 2'b00; b = 2'b00; res = 2'b00;
        case (ph)
            P_FETCH:  begin mreq = 1; a = 2'b01; b = 2'b10; res = 2'b10; irw = r; npc = r; end
            P_DECODE: begin a = 2'b01; b = 2'b10; res = 2'b10; end
            P_EXR:    aop = 1;
            P_EXI:    begin aop = 1; b = 2'b01; end
            P_MULF:   mst = 1;
            P_AWB:    regw = 1;
            P_MADR:   b = 2'b01;
            P_MRD:    begin mreq = 1; adr = 1; end
            P_MWR:    begin mreq = 1; adr = 1; memw = r; end
            P_MWB:    begin regw = 1; res = 2'b01; end
            P_BR:     begin br = 1; a = 2'b10; b = 2'b01; res = 2'b10; end
            P_UNK:    ill = 1;
            P_FAULT:  flt = 1;
            default:  ;
        endcase
        return {mreq, irw, adr, npc, regw, memw, br, aop, a, b, res, mst, ill, flt};
    endfunction

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive MemReady, record what the outputs must be this cycle, advance.
    task automatic step(input bit r, input int ph);
        exp_t e;
        MemReady = r;
        e.w   = cw(ph, r);
        e.tag = pname(ph);
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(rb(), P_FETCH);
        step(rb(), P_FETCH);
        reset = 1'b1;
    endtask

    task automatic fault_reset();
        for (int i = 0; i < 4; i++) step(rb(), P_FAULT);
        do_reset();
    endtask

    // w cycles of MemReady=0 then one ready cycle; the TO-th waiting cycle ends in FAULT.
    task automatic mem_wait(input int ph, input int w, output bit f);
        f = 1'b0;
        for (int i = 0; i < w; i++) begin
            step(1'b0, ph);
            if (i == TO - 1) begin
                f = 1'b1;
                return;
            end
        end
        step(1'b1, ph);
    endtask

    task automatic do_instr(input logic [1:0] op, input logic [5:0] fn, input logic mo,
                            input int fw, input int mw);
        bit f;
        Op = 2'($urandom); Funct = 6'($urandom); MulOp = 1'($urandom);
        mem_wait(P_FETCH, fw, f);
        if (f) begin fault_reset(); return; end
        Op = op; Funct = fn; MulOp = mo;
        step(rb(), P_DECODE);
        if (op == 2'b11) begin
            step(rb(), P_UNK);
        end else if (op == 2'b10) begin
            step(rb(), P_BR);
        end else if (op == 2'b01) begin
            step(rb(), P_MADR);
            if (fn[0]) begin
                mem_wait(P_MRD, mw, f);
                if (f) begin fault_reset(); return; end
                step(rb(), P_MWB);
            end else begin
                mem_wait(P_MWR, mw, f);
                if (f) begin fault_reset(); return; end
            end
        end else if (mo) begin
            for (int i = 0; i < MULC; i++) step(rb(), (i == 0) ? P_MULF : P_MUL);
            step(rb(), P_AWB);
        end else begin
            step(rb(), fn[5] ? P_EXI : P_EXR);
            step(rb(), P_AWB);
        end
    endtask

    task automatic reset_in_memwr();
        exp_t e;
        Op = 2'b01; Funct = 6'b000000; MulOp = 1'b0;
        step(1'b1, P_FETCH);
        step(rb(), P_DECODE);
        step(rb(), P_MADR);
        step(1'b0, P_MWR);
        step(1'b0, P_MWR);
        MemReady = 1'b0;
        reset    = 1'b0;
        #1;
        n_checks++;
        if (MemReq !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset: MemReq=%b required 1 before any clock edge", MemReq);
        end
        n_checks++;
        if (AdrSrc !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: AdrSrc=%b required 0 before any clock edge", AdrSrc);
        end
        n_checks++;
        if (MemW !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: MemW=%b required 0", MemW);
        end
        n_checks++;
        if (Fault !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: Fault=%b required 0", Fault);
        end
        e.w   = cw(P_FETCH, 1'b0);
        e.tag = "async_reset_in_MEMWR";
        expq.push_back(e);
        @(posedge clk);
        #1;
        step(1'b0, P_FETCH);
        reset = 1'b1;
    endtask

    function automatic int rand_wait();
        int k;
        k = $urandom_range(0, 19);
        if (k == 0)      return TO;
        else if (k < 4)  return TO - 1;
        else if (k < 10) return 0;
        else             return $urandom_range(1, TO - 2);
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                cur = expq.pop_front();
                n_checks++;
                if (got !== cur.w) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got %b required %b", cur.tag, $time, got, cur.w);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; Op = 2'b00; Funct = 6'b0; MulOp = 1'b0; MemReady = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        do_instr(2'b00, 6'b000000, 1'b0, 0, 0);
        do_instr(2'b01, 6'b000001, 1'b0, 0, 3);
        do_instr(2'b00, 6'b000000, 1'b1, 0, 0);
        do_instr(2'b00, 6'b100000, 1'b0, 2, 0);
        do_instr(2'b11, 6'b010101, 1'b0, 0, 0);
        do_instr(2'b10, 6'b000000, 1'b0, 1, 0);
        do_instr(2'b01, 6'b000000, 1'b0, TO - 1, TO - 1);
        do_instr(2'b00, 6'b000000, 1'b0, TO, 0);
        do_instr(2'b01, 6'b000001, 1'b0, 0, TO);
        do_instr(2'b01, 6'b000000, 1'b0, 0, TO);
        reset_in_memwr();
        for (int n = 0; n < 300; n++) begin
            do_instr(2'($urandom), 6'($urandom), 1'($urandom), rand_wait(), rand_wait());
        end
        @(negedge clk);
        #1;
        if (n_checks <= 12) begin
            n_fail++;
            $display("FAIL too few checks executed: %0d", n_checks);
        end
        if (n_fail != 0) begin
            $display("FAIL %0d mismatches detected", n_fail);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
